// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming codeword serialiser.
package hamming_pkg;

  localparam int unsigned CW_WIDTH   = 15;
  localparam int unsigned DATA_WIDTH = 11;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/hamming_bit_cnt.sv
// Frame bit counter: synchronous clear, count enable and last-bit flag.
module hamming_bit_cnt
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = CW_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flags the bit whose shift completes the frame.
  assign tc = (cnt == LAST);

endmodule

// File: rtl/hamming_shift_ctrl.sv
// Load/shift sequencer feeding a codeword LSB-first into an external shift register.
module hamming_shift_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned WIDTH = CW_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [WIDTH-1:0] cw_data,
  input  logic             abort,
  input  logic             ser_ready,
  output logic             sr_load,
  output logic             sr_shift,
  output logic [WIDTH-1:0] sr_par,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             frame_done
);

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   cnt_clr;
  logic   cnt_tc;

  assign cw_ready = !RST && ((state == IDLE) || (state == DONE));
  // Abort outranks a handshake, so the codeword is not captured either.
  assign accept   = cw_valid && cw_ready && !abort;
  assign cnt_clr  = abort || (state == LOAD);

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sr_par <= '0;
    end else if (accept) begin
      sr_par <= cw_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = LOAD;
        end
        LOAD: begin
          sr_load   = 1'b1;
          busy      = 1'b1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          busy     = 1'b1;
          sr_shift = ser_ready;
          if (ser_ready && cnt_tc) state_nxt = DONE;
        end
        DONE: begin
          busy       = 1'b1;
          frame_done = 1'b1;
          state_nxt  = accept ? LOAD : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
    end
  end

  hamming_bit_cnt #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk(clk),
    .RST(RST),
    .clr(cnt_clr),
    .en (sr_shift),
    .cnt(bit_cnt),
    .tc (cnt_tc)
  );

endmodule

// File: tb/tb_hamming_shift_ctrl.sv
// Directed and randomized bench for hamming_shift_ctrl against a frame-level reference model.
module tb_hamming_shift_ctrl;

  localparam int unsigned W  = 15;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          RST;
  logic          cw_valid;
  logic          cw_ready;
  logic [W-1:0]  cw_data;
  logic          abort;
  logic          ser_ready;
  logic          sr_load;
  logic          sr_shift;
  logic [W-1:0]  sr_par;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  hamming_shift_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .RST(RST),
    .cw_valid(cw_valid),
    .cw_ready(cw_ready),
    .cw_data(cw_data),
    .abort(abort),
    .ser_ready(ser_ready),
    .sr_load(sr_load),
    .sr_shift(sr_shift),
    .sr_par(sr_par),
    .bit_cnt(bit_cnt),
    .busy(busy),
    .frame_done(frame_done)
  );

  int checks_total = 0;
  int checks_pass  = 0;
  int checks_fail  = 0;

  // Reference model: a frame is pending, has had its load cycle, and has sent m_sent bits.
  bit           m_frame  = 1'b0;
  bit           m_loaded = 1'b0;
  bit           m_done   = 1'b0;
  int           m_sent   = 0;
  int           m_cnt    = 0;
  logic [W-1:0] m_par    = '0;

  int           cyc;
  int           load_cyc, done_cyc, first_shift, last_shift_cyc, n_shift, n_done, done_cnt;
  logic [W-1:0] done_par;
  logic [4:0]   last_outs;
  logic [4:0]   outs_log [64];
  int           cnt_log  [64];
  logic [W-1:0] par_log  [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_pass++;
    else begin
      checks_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    cyc = 0; load_cyc = -1; done_cyc = -1; first_shift = -1; last_shift_cyc = -1;
    n_shift = 0; n_done = 0; done_cnt = -1; done_par = '0;
  endtask

  task automatic tick();
    bit e_ready, e_load, e_shift, e_done, e_busy, hs, fin;
    @(negedge clk);
    e_ready = !RST && !m_frame;
    e_load  = !RST && m_frame && !m_loaded;
    e_shift = !RST && m_frame && m_loaded && ser_ready;
    e_done  = !RST && m_done;
    e_busy  = !RST && (m_frame || m_done);
    chk("cw_ready", cw_ready, e_ready);
    chk("sr_load", sr_load, e_load);
    chk("sr_shift", sr_shift, e_shift);
    chk("frame_done", frame_done, e_done);
    chk("busy", busy, e_busy);
    chk("bit_cnt", bit_cnt, m_cnt);
    chk("sr_par", sr_par, m_par);

    last_outs = {cw_ready, sr_load, sr_shift, busy, frame_done};
    if (cyc < 64) begin
      outs_log[cyc] = last_outs;
      cnt_log[cyc]  = bit_cnt;
      par_log[cyc]  = sr_par;
    end
    if (sr_load) load_cyc = cyc;
    if (sr_shift) begin
      n_shift++;
      if (first_shift < 0) first_shift = cyc;
      last_shift_cyc = cyc;
    end
    if (frame_done) begin
      n_done++; done_cyc = cyc; done_cnt = bit_cnt; done_par = sr_par;
    end

    if (RST) begin
      m_frame = 0; m_loaded = 0; m_done = 0; m_sent = 0; m_cnt = 0; m_par = '0;
    end else if (abort) begin
      m_frame = 0; m_loaded = 0; m_done = 0; m_sent = 0; m_cnt = 0;
    end else begin
      hs  = cw_valid && e_ready;
      fin = 0;
      if (m_frame && !m_loaded) begin
        m_loaded = 1; m_cnt = 0;
      end else if (m_frame && ser_ready) begin
        m_sent++; m_cnt++;
        if (m_sent == W) begin fin = 1; m_frame = 0; end
      end
      m_done = fin;
      if (hs) begin m_frame = 1; m_loaded = 0; m_sent = 0; m_par = cw_data; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  logic [W-1:0] d1, d2;

  initial begin
    RST = 1'b1; cw_valid = 1'b0; abort = 1'b0; ser_ready = 1'b0; cw_data = '0;
    cyc = 0;
    @(posedge clk); #1;

    // Reset held for 3 cycles; inputs toggling must have no effect.
    for (int i = 0; i < 3; i++) begin
      cw_valid = 1'(i % 2 == 0); ser_ready = 1'b1; cw_data = W'($urandom);
      tick();
      chk("rst_outs_zero", last_outs, 5'b00000);
    end
    RST = 1'b0; cw_valid = 1'b0;
    tick();
    chk("ready_after_rst", last_outs, 5'b10000);

    // Nominal frame, ser_ready always high.
    cw_data = 15'h2A5C; cw_valid = 1'b1; ser_ready = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0; cw_data = W'($urandom);
    repeat (20) tick();
    chk("a_load_cyc", load_cyc, 1);
    chk("a_first_shift", first_shift, 2);
    chk("a_last_shift", last_shift_cyc, 16);
    chk("a_n_shift", n_shift, 15);
    chk("a_done_cyc", done_cyc, 17);
    chk("a_n_done", n_done, 1);
    chk("a_done_cnt", done_cnt, 15);
    chk("a_sr_par", done_par, 15'h2A5C);

    // Stall for 4 cycles once 7 bits have gone out.
    cw_data = W'($urandom); cw_valid = 1'b1; ser_ready = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0;
    repeat (25) begin
      ser_ready = !(cyc >= 9 && cyc <= 12);
      tick();
    end
    ser_ready = 1'b1;
    chk("b_cnt_stall_start", cnt_log[9], 7);
    chk("b_cnt_stall_end", cnt_log[12], 7);
    chk("b_no_shift_stall", outs_log[10][2], 1'b0);
    chk("b_done_cyc", done_cyc, 21);
    chk("b_n_shift", n_shift, 15);

    // Abort with 9 bits sent, then a normal frame with random back-pressure.
    cw_data = W'($urandom); cw_valid = 1'b1; ser_ready = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0;
    while (cyc < 12) begin
      abort = (cyc == 11);
      tick();
    end
    abort = 1'b0;
    repeat (20) tick();
    chk("c_cnt_at_abort", cnt_log[11], 9);
    chk("c_idle_after_abort", outs_log[12], 5'b10000);
    chk("c_cnt_cleared", cnt_log[12], 0);
    chk("c_no_done", n_done, 0);

    d1 = W'($urandom); cw_data = d1; cw_valid = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0;
    repeat (60) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("c2_n_done", n_done, 1);
    chk("c2_done_cnt", done_cnt, 15);
    chk("c2_done_par", done_par, d1);

    // Back-to-back frames; cw_valid during SHIFT carries junk that must be ignored.
    d1 = W'($urandom); d2 = ~d1; cw_data = d1; cw_valid = 1'b1; ser_ready = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0;
    while (cyc < 40) begin
      cw_valid = (cyc >= 3 && cyc <= 17);
      cw_data  = (cyc == 17) ? d2 : W'($urandom);
      tick();
    end
    cw_valid = 1'b0;
    chk("d_par_held", par_log[16], d1);
    chk("d_done_cycle", outs_log[17], 5'b10011);
    chk("d_b2b_load", outs_log[18], 5'b01010);
    chk("d_par_second", par_log[18], d2);
    chk("d_done2_cyc", done_cyc, 34);
    chk("d_n_done", n_done, 2);

    // Reset mid-SHIFT together with abort and a handshake attempt.
    cw_data = W'($urandom); cw_valid = 1'b1; ser_ready = 1'b1;
    start_frame();
    tick();
    cw_valid = 1'b0;
    while (cyc < 6) tick();
    RST = 1'b1; abort = 1'b1; cw_valid = 1'b1; cw_data = W'($urandom);
    tick();
    RST = 1'b0; abort = 1'b0; cw_valid = 1'b0;
    repeat (10) tick();
    chk("e_outs_in_rst", outs_log[6], 5'b00000);
    chk("e_idle_after_rst", outs_log[7], 5'b10000);
    chk("e_par_cleared", par_log[7], '0);
    chk("e_cnt_cleared", cnt_log[7], 0);
    chk("e_no_done", n_done, 0);

    // Randomized traffic checked cycle by cycle against the model.
    repeat (400) begin
      RST       = ($urandom_range(0, 63) == 0);
      abort     = ($urandom_range(0, 31) == 0);
      cw_valid  = ($urandom_range(0, 1) == 1);
      ser_ready = ($urandom_range(0, 3) != 0);
      cw_data   = W'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
